// File: rtl/imm_enc.sv
// Immediate encoder: packs a 32-bit immediate into I/S/U/J/B instruction fields and
// expands the LI pseudo-op into one or two words (LUI and/or ADDI) on an output handshake.
//   state | meaning
//   IDLE  | output register empty
//   ONE   | holding the final word of the current request
//   FIRST | holding LUI of a two-word LI; ADDI waits in pending
module imm_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, ONE, FIRST} state_t;

  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_S  = 3'b001;
  localparam logic [2:0] FMT_U  = 3'b010;
  localparam logic [2:0] FMT_LI = 3'b011;
  localparam logic [2:0] FMT_J  = 3'b100;
  localparam logic [2:0] FMT_B  = 3'b101;

  state_t      state;
  logic [31:0] pending;

  logic [31:0] enc_word;
  logic [31:0] enc_pend;
  logic        enc_err;
  logic        enc_two;
  logic [31:0] li_round;
  logic [4:0]  rd;
  logic        fits12;
  logic        accept;
  logic        fire;

  assign rd       = in_base[11:7];
  assign fits12   = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
  assign li_round = in_imm + 32'h0000_0800;

  always_comb begin
    enc_word = in_base;
    enc_pend = 32'h0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (in_fmt)
      FMT_I: begin
        enc_word = {in_imm[11:0], in_base[19:0]};
        enc_err  = !fits12;
      end
      FMT_S: begin
        enc_word = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
        enc_err  = !fits12;
      end
      FMT_U: begin
        enc_word = {in_imm[31:12], in_base[11:0]};
        enc_err  = (in_imm[11:0] != 12'h0);
      end
      FMT_J: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
        enc_err  = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) | in_imm[0];
      end
      FMT_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11], in_base[6:0]};
        enc_err  = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) | in_imm[0];
      end
      FMT_LI: begin
        if (fits12) begin
          enc_word = {in_imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else if (in_imm[11:0] == 12'h0) begin
          enc_word = {in_imm[31:12], rd, 7'h37};
        end else begin
          // LUI rounds up so that the sign-extended ADDI lands on the exact value
          enc_word = {li_round[31:12], rd, 7'h37};
          enc_pend = {in_imm[11:0], rd, 3'b000, rd, 7'h13};
          enc_two  = 1'b1;
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  assign fire     = out_valid & out_ready;
  assign in_ready = (state == IDLE) | (fire & out_last);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      pending   <= 32'h0;
    end else if (accept) begin
      state     <= enc_two ? FIRST : ONE;
      out_valid <= 1'b1;
      out_instr <= enc_word;
      out_last  <= !enc_two;
      out_err   <= enc_err;
      pending   <= enc_pend;
    end else if (fire) begin
      if (state == FIRST) begin
        state     <= ONE;
        out_instr <= pending;
        out_last  <= 1'b1;
        out_err   <= 1'b0;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
